// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at the start edge and released after a fixed busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  multctrl,
    input  logic [1:0]  muwe,
    input  logic [1:0]  mure,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic          start_ok;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;

    // Signed division works on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 on its own.
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign start_ok = (state_q == S_IDLE) && start && !flush && (multctrl inside {[3'd1:3'd4]});

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        q_mag    = 32'd0;
        r_mag    = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = (multctrl <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    case (multctrl)
                        3'd1: {hi_tmp_d, lo_tmp_d} = prod_s;
                        3'd2: {hi_tmp_d, lo_tmp_d} = prod_u;
                        default: begin
                            // Divide by zero reloads the current HI/LO, which cannot change during RUN.
                            if (b == 32'd0) begin
                                hi_tmp_d = hi_q;
                                lo_tmp_d = lo_q;
                            end else if (multctrl == 3'd3) begin
                                q_mag    = a_mag / b_mag;
                                r_mag    = a_mag % b_mag;
                                lo_tmp_d = (a[31] ^ b[31]) ? -q_mag : q_mag;
                                hi_tmp_d = a[31] ? -r_mag : r_mag;
                            end else begin
                                lo_tmp_d = a / b;
                                hi_tmp_d = a % b;
                            end
                        end
                    endcase
                end else if (!flush) begin
                    if (muwe == 2'd1) hi_d = a;
                    if (muwe == 2'd2) lo_d = a;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pending result is reset too, so an aborted operation can never write back.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    always_comb begin
        case (mure)
            2'd1:    out = hi_q;
            2'd2:    out = lo_q;
            default: out = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO pairs are queued at each start
// and popped when busy drops.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  multctrl;
    logic [1:0]  muwe;
    logic [1:0]  mure;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    int   tests  = 0;
    int   failed = 0;
    res_t sb_q[$];
    res_t model_r;

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .multctrl (multctrl),
        .muwe     (muwe),
        .mure     (mure),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .out      (out),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic from the ISA definition, applied to the current architectural HI/LO.
    function automatic res_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input res_t cur);
        res_t r;
        int   sx, sy;
        logic signed [63:0] ps;
        r  = cur;
        sx = x;
        sy = y;
        case (op)
            3'd1: begin
                ps = 64'(sx) * 64'(sy);
                r  = ps;
            end
            3'd2: r = {32'd0, x} * {32'd0, y};
            3'd3: begin
                if (y == 32'd0) r = cur;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    r.lo = sx / sy;
                    r.hi = sx % sy;
                end
            end
            3'd4: begin
                if (y != 32'd0) begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            default: r = cur;
        endcase
        return r;
    endfunction

    // Drives one start cycle; returns at the negedge after the start edge.
    task automatic launch(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start    = 1'b1;
        multctrl = op;
        a        = x;
        b        = y;
        #1 check({tag, "_busy_in_start_cycle"}, 32'(busy), 32'd0);
        model_r = model(op, x, y, model_r);
        sb_q.push_back(model_r);
        @(negedge clk);
        start    = 1'b0;
        multctrl = 3'd0;
    endtask

    // Counts busy negedges (starting from already_seen), then pops and compares the result.
    task automatic wait_done(input string tag, input int already_seen, input int exp_cycles);
        int   n;
        res_t exp_r;
        n = already_seen;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_queue_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            exp_r = sb_q.pop_front();
            check({tag, "_hi"}, hi, exp_r.hi);
            check({tag, "_lo"}, lo, exp_r.lo);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        multctrl = 3'd0;
        muwe     = 2'd0;
        mure     = 2'd0;
        flush    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        model_r  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_out", out, 32'd0);

        // Signed multiply, then read LO in the cycle busy drops
        launch("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult", 0, MULT_CYCLES);
        mure = 2'd2;
        #1 check("mult_out_lo", out, 32'hFFFF_FFFA);
        mure = 2'd0;

        // Unsigned multiply
        launch("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu", 0, MULT_CYCLES);

        // Signed divide
        launch("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 0, DIV_CYCLES);

        // Unsigned divide by zero keeps HI/LO
        launch("divu_by_zero", 3'd4, 32'd7, 32'd0);
        wait_done("divu_by_zero", 0, DIV_CYCLES);

        // Signed overflow case
        launch("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0, DIV_CYCLES);

        // Unsigned divide, non-trivial
        launch("divu", 3'd4, 32'd100, 32'd7);
        wait_done("divu", 0, DIV_CYCLES);

        // mthi while idle, read back through out
        @(negedge clk);
        muwe = 2'd1;
        a    = 32'h1234_5678;
        @(negedge clk);
        muwe = 2'd0;
        model_r.hi = 32'h1234_5678;
        mure = 2'd1;
        #1 check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_out", out, 32'h1234_5678);
        mure = 2'd0;

        // start with multctrl=0 is ignored
        @(negedge clk);
        start    = 1'b1;
        multctrl = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("start_op0_busy", 32'(busy), 32'd0);

        // mtlo and a second start during RUN are both ignored
        launch("div_midrun", 3'd3, 32'd100, 32'hFFFF_FFFD);
        muwe = 2'd2;
        a    = 32'hDEAD_BEEF;
        @(negedge clk);
        muwe     = 2'd0;
        start    = 1'b1;
        multctrl = 3'd1;
        a        = 32'd3;
        b        = 32'd5;
        @(negedge clk);
        start    = 1'b0;
        multctrl = 3'd0;
        wait_done("div_midrun", 2, DIV_CYCLES);
        @(negedge clk);
        check("midrun_no_restart", 32'(busy), 32'd0);

        // Flush gating of start and of mtlo
        @(negedge clk);
        start    = 1'b1;
        multctrl = 3'd1;
        flush    = 1'b1;
        a        = 32'd9;
        b        = 32'd9;
        @(negedge clk);
        start    = 1'b0;
        multctrl = 3'd0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_hi", hi, model_r.hi);
        check("flush_start_lo", lo, model_r.lo);
        muwe = 2'd2;
        a    = 32'hCAFE_0000;
        @(negedge clk);
        muwe  = 2'd0;
        flush = 1'b0;
        check("flush_mtlo_lo", lo, model_r.lo);

        // Asynchronous reset at busy cycle 3 of a mult
        launch("mult_rst", 3'd1, 32'd1000, 32'd1000);
        repeat (2) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_hi", hi, 32'd0);
        check("rst_async_lo", lo, 32'd0);
        void'(sb_q.pop_front());
        model_r = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (MULT_CYCLES + 3) @(negedge clk);
        check("rst_no_late_busy", 32'(busy), 32'd0);
        check("rst_no_late_hi", hi, 32'd0);
        check("rst_no_late_lo", lo, 32'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
